// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: N_REQ request lanes packed into flat
// vectors plus a single registered response channel.
interface shift_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDW = $clog2(N_REQ);

    // Request side, one lane per requester
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_lr;
    logic [4*N_REQ-1:0]     req_shift;
    logic [WIDTH*N_REQ-1:0] req_data;

    // Response side
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic                   busy;

    // Client side: drives requests, consumes responses
    modport master (
        output req_valid, req_lr, req_shift, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_lr, req_shift, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit logical barrel shifter between N_REQ
// requesters. The shifter result is captured in a single output register that
// acts as a one-entry response buffer with valid/ready flow control.
module shift_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst,
    shift_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(N_REQ);
    // N_REQ in a width that can also hold rr_ptr + offset without overflow
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(N_REQ);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_e;

    state_e           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             found;
    logic [IDW-1:0]   winner;
    logic             can_accept;
    logic             fire;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   next_ptr;

    logic [WIDTH-1:0] sel_data;
    logic [3:0]       sel_shift;
    logic             sel_lr;
    logic [WIDTH-1:0] shift_out;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping mod N_REQ
    always_comb begin
        logic [IDW:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && bus.req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // Handshake qualification; reset blocks every grant
    always_comb begin
        can_accept = (state == StEmpty) || bus.rsp_ready;
        fire       = found && can_accept && !rst;
        grant      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = fire && (winner == IDW'(i));
        end
    end

    // Pointer advances to the slot after the winner, wrapping at N_REQ
    always_comb begin
        logic [IDW:0] inc;
        inc = {1'b0, winner} + (IDW + 1)'(1);
        if (inc == NREQ_W) begin
            inc = '0;
        end
        next_ptr = inc[IDW-1:0];
    end

    // Route the winning requester's operands to the shifter
    always_comb begin
        sel_data  = '0;
        sel_shift = '0;
        sel_lr    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_data  = bus.req_data[i*WIDTH +: WIDTH];
                sel_shift = bus.req_shift[i*4 +: 4];
                sel_lr    = bus.req_lr[i];
            end
        end
    end

    // Shift_16bit: four-stage logical barrel shifter, zero fill, lr=1 shifts left
    always_comb begin
        logic [WIDTH-1:0] stage;
        stage = sel_data;
        for (int s = 0; s < 4; s++) begin
            if (sel_shift[s]) begin
                if (sel_lr) begin
                    stage = stage << (1 << s);
                end else begin
                    stage = stage >> (1 << s);
                end
            end
        end
        shift_out = stage;
    end

    // Response buffer FSM: a new transfer always overwrites, a drain alone empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StEmpty;
            rr_ptr     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else if (fire) begin
            state      <= StFull;
            rr_ptr     <= next_ptr;
            rsp_id_q   <= winner;
            rsp_data_q <= shift_out;
        end else if (state == StFull && bus.rsp_ready) begin
            state <= StEmpty;
        end
    end

    // Output drive
    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = (state == StFull);
        bus.busy      = (state == StFull);
        bus.rsp_id    = rsp_id_q;
        bus.rsp_data  = rsp_data_q;
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with 4 requesters. Inputs change 1 ns after the
// rising edge; outputs are compared on the falling edge.
module tb_shift_arbiter;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    shift_arbiter_if #(.N_REQ(4), .WIDTH(16)) bus ();

    shift_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic lr, input logic [3:0] sh,
                           input logic [15:0] d);
        bus.req_valid[i]        = v;
        bus.req_lr[i]           = lr;
        bus.req_shift[4*i +: 4] = sh;
        bus.req_data[16*i +: 16] = d;
    endtask

    // Lone request on lane idx: granted immediately, result one cycle later, then drained
    task automatic one_op(input string tag, input int idx, input logic lr, input logic [3:0] sh,
                          input logic [15:0] d, input logic [15:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        set_req(idx, 1'b1, lr, sh, d);
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(oh));
        tick();
        set_req(idx, 1'b0, lr, sh, d);
        @(negedge clk);
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
        check({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        tick();
    endtask

    initial begin
        logic [3:0] oh;
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_lr    = '0;
        bus.req_shift = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();

        // No grant while reset is held, even with a request pending
        set_req(0, 1'b1, 1'b0, 4'd1, 16'hFF00);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_data", 32'(bus.rsp_data), 32'h0);
        check("reset_id", 32'(bus.rsp_id), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("r1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        set_req(0, 1'b1, 1'b0, 4'd2, 16'hFF00);
        @(negedge clk);
        check("r1_valid", 32'(bus.rsp_valid), 32'h1);
        check("r1_busy", 32'(bus.busy), 32'h1);
        check("r1_data", 32'(bus.rsp_data), 32'h7F80);
        check("r1_id", 32'(bus.rsp_id), 32'h0);
        check("r2_ready", 32'(bus.req_ready), 32'h1);
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 16'h0);
        @(negedge clk);
        check("r2_data", 32'(bus.rsp_data), 32'h3FC0);
        tick();
        @(negedge clk);
        check("drain_valid", 32'(bus.rsp_valid), 32'h0);

        // Left shifts and boundary amounts
        one_op("l1", 1, 1'b1, 4'd1, 16'h00FF, 16'h01FE);
        one_op("l2", 1, 1'b1, 4'd2, 16'h00FF, 16'h03FC);
        one_op("l0", 1, 1'b1, 4'd0, 16'h00FF, 16'h00FF);
        one_op("l15", 1, 1'b1, 4'd15, 16'h00FF, 16'h8000);
        one_op("r15", 0, 1'b0, 4'd15, 16'h00FF, 16'h0000);

        // Round-robin with every lane requesting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 1'b0, 4'd0, 16'(16'h1111 * (i + 1)));
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            oh = 4'b0001 << (c % 4);
            check("rr_ready", 32'(bus.req_ready), 32'(oh));
            if (c > 0) begin
                check("rr_id", 32'(bus.rsp_id), 32'((c - 1) % 4));
                check("rr_data", 32'(bus.rsp_data), 32'(16'h1111 * (((c - 1) % 4) + 1)));
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 1'b0, 4'd0, 16'h0);
        end
        @(negedge clk);
        check("rr_last_id", 32'(bus.rsp_id), 32'h1);
        check("rr_last_data", 32'(bus.rsp_data), 32'h2222);
        tick();

        // Backpressure: pointer is at 2 here
        set_req(2, 1'b1, 1'b0, 4'd4, 16'h1234);
        @(negedge clk);
        check("bp_ready2", 32'(bus.req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(0, 1'b1, 1'b0, 4'd0, 16'hAAAA);
        set_req(3, 1'b1, 1'b1, 4'd1, 16'h8001);
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
            check("bp_hold_data", 32'(bus.rsp_data), 32'h0123);
            check("bp_hold_id", 32'(bus.rsp_id), 32'h2);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.req_ready), 32'h8);
        tick();
        set_req(3, 1'b0, 1'b0, 4'd0, 16'h0);
        @(negedge clk);
        check("bp_r3_data", 32'(bus.rsp_data), 32'h0002);
        check("bp_r3_id", 32'(bus.rsp_id), 32'h3);
        check("bp_r0_ready", 32'(bus.req_ready), 32'h1);
        tick();

        // Walk pointer to 2 with a result held, then reset
        set_req(0, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(1, 1'b1, 1'b0, 4'd0, 16'h5555);
        @(negedge clk);
        check("pre_r0_data", 32'(bus.rsp_data), 32'hAAAA);
        tick();
        bus.rsp_ready = 1'b0;
        set_req(3, 1'b1, 1'b0, 4'd0, 16'h3333);
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_id", 32'(bus.rsp_id), 32'h1);
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
        check("in_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_data", 32'(bus.rsp_data), 32'h0);
        check("mid_rst_id", 32'(bus.rsp_id), 32'h0);
        check("post_rst_ready", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(3, 1'b0, 1'b0, 4'd0, 16'h0);
        @(negedge clk);
        check("post_rst_id", 32'(bus.rsp_id), 32'h1);
        check("post_rst_data", 32'(bus.rsp_data), 32'h5555);
        bus.rsp_ready = 1'b1;
        tick();

        // Sparse: only req3, then only req1, back to back; pointer is at 2 here
        set_req(3, 1'b1, 1'b0, 4'd8, 16'hF000);
        @(negedge clk);
        check("sp_ready3", 32'(bus.req_ready), 32'h8);
        tick();
        set_req(3, 1'b0, 1'b0, 4'd0, 16'h0);
        set_req(1, 1'b1, 1'b1, 4'd4, 16'h0F0F);
        @(negedge clk);
        check("sp_ready1", 32'(bus.req_ready), 32'h2);
        check("sp_id3", 32'(bus.rsp_id), 32'h3);
        check("sp_data3", 32'(bus.rsp_data), 32'h00F0);
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 16'h0);
        @(negedge clk);
        check("sp_id1", 32'(bus.rsp_id), 32'h1);
        check("sp_data1", 32'(bus.rsp_data), 32'hF0F0);
        check("sp_valid1", 32'(bus.rsp_valid), 32'h1);
        tick();
        @(negedge clk);
        check("sp_drain", 32'(bus.rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit logical barrel shifter (Shift_16bit) between N_REQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on every request port and on the single response port.
- The shifter result is registered, so the response port has one output register of buffering.
- Sits between multiple datapath clients and the shared Shift_16bit instance, which is instantiated inside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8); requester ID width is IDW = clog2(N_REQ).
- WIDTH, 16, data width; fixed to match Shift_16bit.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  request valid, one bit per requester.
- req_ready  output  N_REQ  grant/accept, one-hot or zero.
- req_lr  input  N_REQ  direction per requester: 0 = right, 1 = left.
- req_shift  input  4*N_REQ  shift amount 0..15; requester i uses [4i+3:4i].
- req_data  input  16*N_REQ  operand; requester i uses [16i+15:16i].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_data  output  16  shifted result.
- busy  output  1  equals rsp_valid; provided for status.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=16'h0000.
  - Round-robin pointer rr_ptr=0, meaning requester 0 has highest priority.
  - req_ready=0 while rst is high.
- Shift semantics (logical, zero-fill):
  - lr=0: out = in >> shift.
  - lr=1: out = in << shift.
  - shift=0 passes data unchanged. Bits shifted out are lost; no rotate.
- States:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1, holding the result).
- Accept condition: can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational, within the cycle):
  - Among requesters with req_valid=1, select the first found searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0.
- Transfer on a clock edge where req_valid[w] && req_ready[w]:
  - Route the winner's operands to Shift_16bit.
  - Register rsp_data <= shifter output, rsp_id <= w, rsp_valid <= 1.
  - rr_ptr <= (w+1) mod N_REQ.
  - Latency: result visible exactly 1 cycle after the handshake edge.
- Response handshake:
  - If rsp_valid && rsp_ready and there is no new transfer: rsp_valid <= 0.
  - Simultaneous response drain and new grant in the same cycle: the new result overwrites. Throughput is 1 op/cycle when rsp_ready is held at 1.
- Backpressure:
  - While rsp_valid && !rsp_ready: all req_ready=0.
  - rsp_data and rsp_id are held stable.
  - rr_ptr is unchanged.
- Requester rules:
  - A requester may change operands while not granted.
  - Operands are sampled only at the handshake edge.
  - Dropping req_valid without a handshake is legal; no state change results.
- Pointer behaviour: rr_ptr moves only on a grant. Wrap-around from N_REQ-1 goes to 0.
- Reset mid-operation: a pending result is discarded (rsp_valid=0) and rr_ptr returns to 0 in the same cycle rst is sampled high.
- No combinational path from rsp_ready to rsp_data. A combinational rsp_ready→req_ready path is allowed.

Test Plan:
- Single request, right shift:
  - Stimulus: req0 data=16'hFF00, shift=1, lr=0, rsp_ready=1.
  - Required: next cycle rsp_valid=1, rsp_data=16'h7F80, rsp_id=0. Then shift=2 gives 16'h3FC0.
- Left shift and boundary amounts:
  - req1 data=16'h00FF, lr=1, shift=1 → 16'h01FE; shift=2 → 16'h03FC.
  - shift=0 → 16'h00FF.
  - shift=15 → 16'h8000.
  - Right shift, shift=15, data=16'h00FF → 16'h0000.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, rsp_ready=1, from reset.
  - Required: grant order 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence matches; exactly one req_ready high per cycle.
- Backpressure:
  - Stimulus: req2 granted, then rsp_ready=0 for 3 cycles with req0 and req3 pending.
  - Required: rsp_data/rsp_id held and req_ready=0 throughout.
  - On rsp_ready=1: req3 is granted in that same cycle (rr_ptr=3), and its result appears the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while rsp_valid=1 and rr_ptr=2.
  - Required: next cycle rsp_valid=0, rsp_data=16'h0000, rsp_id=0. The first grant after reset goes to the lowest valid index.
- Sparse requests:
  - Stimulus: only req3 valid, then only req1 valid.
  - Required: no idle cycles inserted; rr_ptr after the req3 grant is 0, and req1 is still granted immediately.
